// File: rtl/button_pkg.sv
// Shared types and sizing helpers for the button debouncer.
// Holds the press-tracking state enum and the counter width function.
package button_pkg;

  typedef enum logic [1:0] {
    RELEASED = 2'd0,
    PRESSED  = 2'd1,
    HELD     = 2'd2
  } btn_state_e;

  // Bits needed to hold values 0..max(a, b).
  function automatic int cnt_w(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/synchronizer.sv
// Multi-flop synchronizer for asynchronous inputs.
// Ports: clk, n_rst (async low), i_data -> o_data after SYNC_DEPTH edges.
module synchronizer #(
  parameter int   DATA_WIDTH = 1,
  parameter int   SYNC_DEPTH = 2,
  parameter logic RESET_VAL  = 1'b0
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic [DATA_WIDTH-1:0] o_data
);

  logic [SYNC_DEPTH-1:0][DATA_WIDTH-1:0] sync_q;
  logic [SYNC_DEPTH-1:0][DATA_WIDTH-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[SYNC_DEPTH-2:0], i_data};
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sync_q <= {(SYNC_DEPTH * DATA_WIDTH){RESET_VAL}};
    end else begin
      sync_q <= sync_d;
    end
  end

  assign o_data = sync_q[SYNC_DEPTH-1];

endmodule

// File: rtl/button_debouncer.sv
// Debounces a raw button input; emits level, press/release, hold, repeat.
// Ports: clk, n_rst, i_async -> o_level, o_press, o_release, o_hold, o_repeat.
module button_debouncer
  import button_pkg::*;
#(
  parameter int SYNC_DEPTH      = 2,
  parameter int ACTIVE_LOW      = 0,
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int HOLD_CYCLES     = 500000,
  parameter int REPEAT_CYCLES   = 100000
) (
  input  logic clk,
  input  logic n_rst,
  input  logic i_async,
  output logic o_level,
  output logic o_press,
  output logic o_release,
  output logic o_hold,
  output logic o_repeat
);

  localparam int   DW  = cnt_w(DEBOUNCE_CYCLES, 0);
  localparam int   HW  = cnt_w(HOLD_CYCLES, REPEAT_CYCLES);
  localparam logic POL = (ACTIVE_LOW != 0);
  localparam bit   REP_EN = (REPEAT_CYCLES > 0);

  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [HW-1:0] REP_LAST  =
    HW'(REP_EN ? REPEAT_CYCLES - 1 : 0);

  logic sync_out;
  logic s;

  logic [DW-1:0] deb_cnt_q, deb_cnt_d;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  btn_state_e    state_q, state_d;

  logic level_q, level_d;
  logic press_q, press_d;
  logic release_q, release_d;
  logic hold_q, hold_d;
  logic repeat_q, repeat_d;

  logic rise, fall, hold_tc, rep_tc;

  // Reset the chain to the idle pin level so a pin already asserted
  // at reset release is seen as a fresh edge with full latency.
  synchronizer #(
    .DATA_WIDTH(1),
    .SYNC_DEPTH(SYNC_DEPTH),
    .RESET_VAL (POL)
  ) u_sync (
    .clk   (clk),
    .n_rst (n_rst),
    .i_data(i_async),
    .o_data(sync_out)
  );

  assign s = sync_out ^ POL;

  always_comb begin
    deb_cnt_d = '0;
    level_d   = level_q;
    rise      = 1'b0;
    fall      = 1'b0;
    if (s != level_q) begin
      if (deb_cnt_q == DEB_LAST) begin
        level_d = s;
        rise    = s;
        fall    = !s;
      end else begin
        deb_cnt_d = deb_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= RELEASED;
      hold_cnt_q <= '0;
      deb_cnt_q  <= '0;
      level_q    <= 1'b0;
      press_q    <= 1'b0;
      release_q  <= 1'b0;
      hold_q     <= 1'b0;
      repeat_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      deb_cnt_q  <= deb_cnt_d;
      level_q    <= level_d;
      press_q    <= press_d;
      release_q  <= release_d;
      hold_q     <= hold_d;
      repeat_q   <= repeat_d;
    end
  end

  // A debounced fall beats a same-cycle hold/repeat terminal count.
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    hold_tc    = 1'b0;
    rep_tc     = 1'b0;
    unique case (state_q)
      RELEASED: begin
        if (rise) begin
          state_d    = PRESSED;
          hold_cnt_d = '0;
        end
      end
      PRESSED: begin
        if (fall) begin
          state_d    = RELEASED;
          hold_cnt_d = '0;
        end else if (hold_cnt_q == HOLD_LAST) begin
          state_d    = HELD;
          hold_cnt_d = '0;
          hold_tc    = 1'b1;
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      HELD: begin
        if (fall) begin
          state_d    = RELEASED;
          hold_cnt_d = '0;
        end else if (REP_EN) begin
          if (hold_cnt_q == REP_LAST) begin
            hold_cnt_d = '0;
            rep_tc     = 1'b1;
          end else begin
            hold_cnt_d = hold_cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d    = RELEASED;
        hold_cnt_d = '0;
      end
    endcase
  end

  always_comb begin
    press_d   = rise;
    release_d = fall;
    hold_d    = hold_tc;
    repeat_d  = rep_tc;
  end

  assign o_level   = level_q;
  assign o_press   = press_q;
  assign o_release = release_q;
  assign o_hold    = hold_q;
  assign o_repeat  = repeat_q;

endmodule

// File: doc/button_debouncer.md
Name: button_debouncer

Overview:
- Conditions a raw asynchronous mechanical input (button or switch) into a clean, debounced level and event pulses.
- Sits directly upstream of edge/event consumers; its o_level is the stable signal downstream edge detection operates on.
- Adds press/release pulses and hold/auto-repeat events, so UI logic needs no per-input timers.

Parameters:
- SYNC_DEPTH, 2, number of synchronizer flops on i_async (>= 2).
- ACTIVE_LOW, 0, 1 = input asserted when electrically low (pull-up buttons).
- DEBOUNCE_CYCLES, 1000, consecutive stable cycles required to accept a level change (>= 1).
- HOLD_CYCLES, 500000, cycles after o_press before o_hold fires (>= 1).
- REPEAT_CYCLES, 100000, o_repeat period after o_hold; 0 disables repeat.

Ports:
- clk  input  1  system clock.
- n_rst  input  1  reset, asynchronous, active-low.
- i_async  input  1  raw asynchronous button input.
- o_level  output  1  debounced level; 1 = asserted, polarity-corrected.
- o_press  output  1  one-cycle pulse when o_level rises.
- o_release  output  1  one-cycle pulse when o_level falls.
- o_hold  output  1  one-cycle pulse HOLD_CYCLES cycles after o_press while still pressed.
- o_repeat  output  1  one-cycle pulse every REPEAT_CYCLES cycles after o_hold while still pressed.

Behaviour:
- Reset (n_rst low, async):
  - All outputs 0.
  - Counters 0, FSM = RELEASED.
  - o_level = 0 regardless of the pin. If the input is asserted at reset release, a normal press is reported after debounce.
- Synchronization:
  - Instantiate the existing synchronizer with DATA_WIDTH=1 and SYNC_DEPTH.
  - s = sync_out XOR ACTIVE_LOW.
- Debounce:
  - deb_cnt clears on any cycle where s == o_level.
  - deb_cnt increments on any cycle where s != o_level.
  - On a cycle where s != o_level and deb_cnt == DEBOUNCE_CYCLES-1: o_level <= s and deb_cnt <= 0.
  - Latency from i_async edge to o_level change = SYNC_DEPTH + DEBOUNCE_CYCLES cycles.
  - Glitches shorter than DEBOUNCE_CYCLES synchronized cycles produce no output change.
- o_press and o_release:
  - Registered; asserted in the same cycle o_level first shows the new value.
  - Never both high. Each is exactly one cycle wide.
- FSM states: RELEASED, PRESSED, HELD.
  - RELEASED -> PRESSED on debounced rise (o_press); hold_cnt <= 0.
  - In PRESSED, hold_cnt increments each cycle. When hold_cnt == HOLD_CYCLES-1: o_hold pulses next cycle, state -> HELD, hold_cnt <= 0.
  - o_hold is therefore high exactly HOLD_CYCLES cycles after the o_press cycle.
  - In HELD with REPEAT_CYCLES > 0: hold_cnt increments. When hold_cnt == REPEAT_CYCLES-1, o_repeat pulses next cycle and hold_cnt <= 0.
  - In HELD with REPEAT_CYCLES == 0: no counting, o_repeat stays 0.
  - PRESSED or HELD -> RELEASED on debounced fall (o_release); hold_cnt <= 0.
  - A release takes priority over a same-cycle hold/repeat terminal count: no o_hold/o_repeat pulse is emitted.
- Widths:
  - deb_cnt = $clog2(DEBOUNCE_CYCLES+1).
  - hold_cnt = $clog2(max(HOLD_CYCLES, REPEAT_CYCLES)+1).
  - Counters saturate-free by construction: they are cleared before overflow.
- All outputs driven directly from flops; no combinational path from i_async.
- Reset mid-hold: returns to RELEASED with outputs 0 immediately; no release pulse is emitted.

Decomposition:
- Shared package button_pkg:
  - State enum (RELEASED, PRESSED, HELD) as a 2-bit typedef.
  - Width helper function for counter sizing.
- Sub-modules:
  - Reuse the existing synchronizer module.
  - No new sub-module; debounce counter and FSM stay in this block.

Test Plan:
(Parameters SYNC_DEPTH=2, DEBOUNCE_CYCLES=4, HOLD_CYCLES=10, REPEAT_CYCLES=3, ACTIVE_LOW=0 unless noted.)
- Clean press: i_async 0->1 at cycle 0 and held -> o_level=1 and o_press=1 at cycle 6, o_press low at cycle 7; no o_release.
- Bounce: i_async toggles 1,0,1,0 every 2 cycles, then stays 1 -> no o_press during bouncing; o_press exactly 6 cycles after the final stable edge.
- Hold/repeat: press and hold 25 cycles past o_press -> o_hold at o_press+10; o_repeat at +13, +16, +19, +22, +25; each a single cycle.
- Release during HELD: release at o_press+14 -> o_release 6 cycles later; o_repeat stops; FSM returns to RELEASED; no spurious pulses afterward.
- ACTIVE_LOW=1, input held low through reset release -> o_level=0 after reset, then o_press at cycle 6 after release.
- Async reset mid-HELD: n_rst pulsed low -> all outputs 0 immediately; no o_release; re-press behaves as a clean press.
